push_conditioner: RTL and testbench

//  Input-side companion to the FND up/down counters: conditions raw active-low push

---
 rtl/push_pkg.sv | 18 +
 rtl/key_debounce_fsm.sv | 144 ++++++++++++++
 rtl/push_conditioner.sv | 36 +++
 tb/tb_push_conditioner.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/push_pkg.sv
// push_pkg: shared types and helpers for the push-button conditioner.
// Holds the per-key repeat FSM state and the repeat-counter width helper.
package push_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } key_state_e;

    // Counter width able to hold max(dly, per) without wrapping.
    function automatic int rc_width(input int dly, input int per);
        int mx;
        mx = (dly > per) ? dly : per;
        return (mx < 1) ? 1 : $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// key_debounce_fsm: one push button -> synchronised, debounced level,
// press/release pulses and auto-repeat ticks while held.
// Ports: i_Clk, i_Rst (sync, active-high), i_Push (raw, active-low),
//        o_Level, o_Press, o_Release, o_Repeat (all registered).
module key_debounce_fsm
    import push_pkg::*;
#(
    parameter int DB_CYC      = 500_000,
    parameter int RPT_DLY_CYC = 25_000_000,
    parameter int RPT_PER_CYC = 5_000_000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Push,
    output logic o_Level,
    output logic o_Press,
    output logic o_Release,
    output logic o_Repeat
);

    localparam int DB_W = $clog2(DB_CYC);
    localparam int RC_W = rc_width(RPT_DLY_CYC, RPT_PER_CYC);
    localparam bit RPT_EN = (RPT_DLY_CYC > 0);

    localparam logic [DB_W-1:0] DB_LAST =
        DB_W'(DB_CYC - 1);
    localparam logic [RC_W-1:0] DLY_LAST =
        RC_W'(RPT_EN ? RPT_DLY_CYC - 1 : 0);
    localparam logic [RC_W-1:0] PER_LAST =
        RC_W'(RPT_PER_CYC - 1);

    logic            sync_q1;
    logic            sync_q2;
    logic            samp;
    logic [DB_W-1:0] db_q;
    logic            level_q;
    logic            press_q;
    logic            release_q;
    logic            repeat_q;
    logic            repeat_d;
    logic [RC_W-1:0] rc_q;
    logic [RC_W-1:0] rc_d;
    key_state_e      state_q;
    key_state_e      state_d;

    logic differ;
    logic flip;
    logic rise;
    logic fall;

    // Raw button is active-low; sample is active-high.
    assign samp   = ~sync_q2;
    assign differ = (samp != level_q);
    assign flip   = differ && (db_q == DB_LAST);
    assign rise   = flip && samp;
    assign fall   = flip && !samp;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync_q1   <= 1'b1;
            sync_q2   <= 1'b1;
            db_q      <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q1   <= i_Push;
            sync_q2   <= sync_q1;
            press_q   <= rise;
            release_q <= fall;
            if (flip) begin
                level_q <= samp;
                db_q    <= '0;
            end else if (differ) begin
                db_q <= db_q + 1'b1;
            end else begin
                // Input agrees with level again: glitch dropped.
                db_q <= '0;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q  <= IDLE;
            rc_q     <= '0;
            repeat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rc_q     <= rc_d;
            repeat_q <= repeat_d;
        end
    end

    // Press and the delay start share an edge, so the first tick lands
    // exactly RPT_DLY_CYC cycles after o_Press. A release on the same
    // edge as a tick cancels the tick.
    always_comb begin
        state_d  = state_q;
        rc_d     = rc_q;
        repeat_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                rc_d = '0;
                if (rise && RPT_EN) begin
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (fall) begin
                    state_d = IDLE;
                    rc_d    = '0;
                end else if (rc_q == DLY_LAST) begin
                    state_d  = REPEAT;
                    rc_d     = '0;
                    repeat_d = 1'b1;
                end else begin
                    rc_d = rc_q + 1'b1;
                end
            end
            REPEAT: begin
                if (fall) begin
                    state_d = IDLE;
                    rc_d    = '0;
                end else if (rc_q == PER_LAST) begin
                    rc_d     = '0;
                    repeat_d = 1'b1;
                end else begin
                    rc_d = rc_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                rc_d    = '0;
            end
        endcase
    end

    assign o_Level   = level_q;
    assign o_Press   = press_q;
    assign o_Release = release_q;
    assign o_Repeat  = repeat_q;

endmodule

// File: rtl/push_conditioner.sv
// push_conditioner: NUM_KEYS raw active-low buttons -> clean key events.
// Ports: i_Clk, i_Rst, i_Push[NUM_KEYS], o_Level/o_Press/o_Release/o_Repeat.
module push_conditioner
    import push_pkg::*;
#(
    parameter int NUM_KEYS    = 2,
    parameter int DB_CYC      = 500_000,
    parameter int RPT_DLY_CYC = 25_000_000,
    parameter int RPT_PER_CYC = 5_000_000
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic [NUM_KEYS-1:0] i_Push,
    output logic [NUM_KEYS-1:0] o_Level,
    output logic [NUM_KEYS-1:0] o_Press,
    output logic [NUM_KEYS-1:0] o_Release,
    output logic [NUM_KEYS-1:0] o_Repeat
);

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce_fsm #(
            .DB_CYC      (DB_CYC),
            .RPT_DLY_CYC (RPT_DLY_CYC),
            .RPT_PER_CYC (RPT_PER_CYC)
        ) u_key (
            .i_Clk     (i_Clk),
            .i_Rst     (i_Rst),
            .i_Push    (i_Push[k]),
            .o_Level   (o_Level[k]),
            .o_Press   (o_Press[k]),
            .o_Release (o_Release[k]),
            .o_Repeat  (o_Repeat[k])
        );
    end

endmodule

// File: tb/tb_push_conditioner.sv
// tb_push_conditioner: directed checks of debounce, pulses, repeat, reset.
// DB_CYC=4, RPT_DLY_CYC=10, RPT_PER_CYC=3, two keys.
module tb_push_conditioner;

    logic       i_Clk = 1'b0;
    logic       i_Rst = 1'b1;
    logic [1:0] i_Push = 2'b11;
    logic [1:0] o_Level;
    logic [1:0] o_Press;
    logic [1:0] o_Release;
    logic [1:0] o_Repeat;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int press_cyc [2];
    int rep_cnt   [2];
    int rel_cnt   [2];
    int press_cnt [2];
    int any_out   = 0;
    int offs1 [$];

    push_conditioner #(
        .NUM_KEYS    (2),
        .DB_CYC      (4),
        .RPT_DLY_CYC (10),
        .RPT_PER_CYC (3)
    ) dut (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Push    (i_Push),
        .o_Level   (o_Level),
        .o_Press   (o_Press),
        .o_Release (o_Release),
        .o_Repeat  (o_Repeat)
    );

    always #10 i_Clk = ~i_Clk;

    always @(posedge i_Clk) cyc <= cyc + 1;

    initial begin
        for (int k = 0; k < 2; k++) begin
            press_cyc[k] = 0;
            rep_cnt[k]   = 0;
            rel_cnt[k]   = 0;
            press_cnt[k] = 0;
        end
    end

    always @(negedge i_Clk) begin
        if ((o_Level | o_Press | o_Release | o_Repeat) != 2'b00)
            any_out = any_out + 1;
        for (int k = 0; k < 2; k++) begin
            if (o_Press[k]) begin
                press_cyc[k] = cyc;
                press_cnt[k] = press_cnt[k] + 1;
            end
            if (o_Release[k]) rel_cnt[k] = rel_cnt[k] + 1;
            if (o_Repeat[k]) begin
                rep_cnt[k] = rep_cnt[k] + 1;
                if (k == 1) offs1.push_back(cyc - press_cyc[1]);
            end
        end
    end

    task automatic check(input string tag, input int act,
                         input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_Clk);
            #1;
        end
    endtask

    task automatic wait_level(input int k, input logic v,
                              output int n);
        n = 0;
        while (o_Level[k] !== v && n < 50) begin
            step(1);
            n++;
        end
    endtask

    int n;
    int base;
    int b_rep0;
    int b_rel0;
    int b_press0;

    initial begin
        // 1: reset state and quiet after reset
        step(2);
        check("rst_level",   o_Level,   0);
        check("rst_press",   o_Press,   0);
        check("rst_release", o_Release, 0);
        check("rst_repeat",  o_Repeat,  0);
        i_Rst = 1'b0;
        base = any_out;
        step(20);
        check("idle_quiet", any_out - base, 0);

        // 2: 3-cycle glitch is rejected
        b_press0 = press_cnt[0];
        base = any_out;
        i_Push[0] = 1'b0;
        step(3);
        i_Push[0] = 1'b1;
        step(15);
        check("glitch_press", press_cnt[0] - b_press0, 0);
        check("glitch_any",   any_out - base, 0);

        // 3: clean press and release on key 0
        b_rep0 = rep_cnt[0];
        i_Push[0] = 1'b0;
        wait_level(0, 1'b1, n);
        check("k0_press_lat", n, 6);
        check("k0_press",     o_Press, 2'b01);
        step(1);
        check("k0_press_1cy", o_Press, 0);
        i_Push[0] = 1'b1;
        wait_level(0, 1'b0, n);
        check("k0_rel_lat",   n, 6);
        check("k0_release",   o_Release, 2'b01);
        step(1);
        check("k0_rel_1cy",   o_Release, 0);
        check("k0_no_repeat", rep_cnt[0] - b_rep0, 0);
        step(10);

        // 4: repeat schedule on key 1, release on a would-be tick
        base = offs1.size();
        i_Push[1] = 1'b0;
        wait_level(1, 1'b1, n);
        check("k1_press_lat", n, 6);
        step(25);
        i_Push[1] = 1'b1;
        step(6);
        check("k1_release",  o_Release, 2'b10);
        check("k1_rel_norep", o_Repeat, 0);
        step(20);
        check("k1_rep_count", offs1.size() - base, 7);
        for (int i = 0; i < 7; i++)
            if (base + i < offs1.size())
                check($sformatf("k1_rep_off%0d", i),
                      offs1[base + i], 10 + 3 * i);

        // 5: simultaneous press, key 0 released mid-DELAY
        base   = offs1.size();
        b_rep0 = rep_cnt[0];
        i_Push = 2'b00;
        wait_level(0, 1'b1, n);
        check("both_press_lat", n, 6);
        check("both_press",     o_Press, 2'b11);
        step(3);
        i_Push[0] = 1'b1;
        step(22);
        i_Push[1] = 1'b1;
        step(6);
        check("both_k1_rel", o_Release, 2'b10);
        step(10);
        check("both_k0_norep", rep_cnt[0] - b_rep0, 0);
        check("both_k1_count", offs1.size() - base, 7);
        for (int i = 0; i < 7; i++)
            if (base + i < offs1.size())
                check($sformatf("both_k1_off%0d", i),
                      offs1[base + i], 10 + 3 * i);

        // 6: reset while key 0 is in REPEAT
        b_rep0 = rep_cnt[0];
        i_Push[0] = 1'b0;
        wait_level(0, 1'b1, n);
        check("rr_press_lat", n, 6);
        step(12);
        check("rr_in_repeat", rep_cnt[0] - b_rep0, 1);
        b_rel0 = rel_cnt[0];
        i_Rst = 1'b1;
        step(1);
        check("rr_level",   o_Level,   0);
        check("rr_press",   o_Press,   0);
        check("rr_release", o_Release, 0);
        check("rr_repeat",  o_Repeat,  0);
        i_Rst = 1'b0;
        wait_level(0, 1'b1, n);
        check("rr_repress_lat", n, 6);
        check("rr_repress",     o_Press, 2'b01);
        check("rr_no_release",  rel_cnt[0] - b_rel0, 0);
        i_Push[0] = 1'b1;
        step(10);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
